io_switch_led_ctrl: RTL and testbench

Memory-mapped IO device block sitting directly downstream of the memory/IO steering stage. It consumes the LEDCtrl/SwitchCtrl strobes, the address and the write data from that stage, and returns the 16-bit io_rdata it consumes on IO reads. It holds the LED output register and synchronises and debounces the board switches. It also keeps a sticky "switches changed" flag that clears when read.

---
 rtl/io_switch_led_ctrl.sv | 131 +++++++++++++
 tb/tb_io_switch_led_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_switch_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : io_switch_led_ctrl
// Description : Memory-mapped LED output register and debounced switch input
//               port. Board switches pass through a two-flop synchroniser and
//               a whole-vector debouncer. A sticky "switches changed" flag is
//               set when a new debounced value commits and is cleared when
//               the status address is read.
// Ports       : clk        - system clock, rising-edge active
//               rst        - synchronous reset, active high
//               LEDCtrl    - IO write strobe
//               SwitchCtrl - IO read strobe
//               addr       - 32-bit byte address, full compare
//               wdata      - IO write data, [LED_WIDTH-1:0] used
//               switch_in  - raw asynchronous board switches
//               led_out    - registered LED drive
//               io_rdata   - combinational IO read data
// Revision    : 1.0 - initial release
// ============================================================================
module io_switch_led_ctrl #(
  parameter int unsigned SW_WIDTH        = 16,
  parameter int unsigned LED_WIDTH       = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter logic [31:0] LED_ADDR        = 32'hFFFF_FC60,
  parameter logic [31:0] SW_ADDR         = 32'hFFFF_FC70,
  parameter logic [31:0] STAT_ADDR       = 32'hFFFF_FC74
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 LEDCtrl,
  input  logic                 SwitchCtrl,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  input  logic [SW_WIDTH-1:0]  switch_in,
  output logic [LED_WIDTH-1:0] led_out,
  output logic [15:0]          io_rdata
);

  localparam int unsigned         CNT_W     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]    c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [LED_WIDTH-1:0] r_led;
  logic [SW_WIDTH-1:0]  r_sync1;
  logic [SW_WIDTH-1:0]  r_sync2;
  logic [SW_WIDTH-1:0]  r_cand;
  logic [CNT_W-1:0]     r_cnt;
  logic [SW_WIDTH-1:0]  r_stable;
  logic                 r_changed;

  logic w_led_wr;
  logic w_sw_rd;
  logic w_stat_rd;
  logic w_cand_hit;
  logic w_commit;
  logic w_unused;

  assign w_led_wr  = LEDCtrl    && (addr == LED_ADDR);
  assign w_sw_rd   = SwitchCtrl && (addr == SW_ADDR);
  assign w_stat_rd = SwitchCtrl && (addr == STAT_ADDR);

  // The candidate has been seen unchanged for the full window.
  assign w_cand_hit = (r_sync2 == r_cand) && (r_cnt == c_CNT_MAX);
  assign w_commit   = w_cand_hit && (r_cand != r_stable);

  // Upper write-data bits are not used by this device.
  assign w_unused = &{1'b0, wdata[31:LED_WIDTH]};

  // LED register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_led <= '0;
    end else if (w_led_wr) begin
      r_led <= wdata[LED_WIDTH-1:0];
    end
  end

  // Two-flop synchroniser for the asynchronous switches
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= switch_in;
      r_sync2 <= r_sync1;
    end
  end

  // Whole-vector debouncer: any bit change restarts the single counter,
  // which saturates at the window end instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cand   <= '0;
      r_cnt    <= '0;
      r_stable <= '0;
    end else if (r_sync2 != r_cand) begin
      r_cand <= r_sync2;
      r_cnt  <= '0;
    end else if (r_cnt == c_CNT_MAX) begin
      if (w_commit) begin
        r_stable <= r_cand;
      end
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Sticky change flag: a commit on the same edge as a status read wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_changed <= 1'b0;
    end else if (w_commit) begin
      r_changed <= 1'b1;
    end else if (w_stat_rd) begin
      r_changed <= 1'b0;
    end
  end

  // Read mux, no latency
  always_comb begin
    io_rdata = 16'h0000;
    if (w_sw_rd) begin
      io_rdata = 16'(r_stable);
    end else if (w_stat_rd) begin
      io_rdata = {15'b0, r_changed};
    end
  end

  assign led_out = r_led;

endmodule
`default_nettype wire

// File: tb/tb_io_switch_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_switch_led_ctrl
// Description : Self-checking bench for io_switch_led_ctrl with a short
//               debounce window. A behavioural model tracks how long the
//               synchronised switch value has been unchanged and checks LED
//               and read data every cycle; directed scenarios pin exact
//               edge timing with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_switch_led_ctrl;

  localparam int          c_D     = 4;
  localparam logic [31:0] c_LED   = 32'hFFFF_FC60;
  localparam logic [31:0] c_SW    = 32'hFFFF_FC70;
  localparam logic [31:0] c_STAT  = 32'hFFFF_FC74;
  localparam logic [31:0] c_OTHER = 32'hFFFF_FC64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        LEDCtrl = 1'b0;
  logic        SwitchCtrl = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [15:0] switch_in = 16'h0;
  logic [15:0] led_out;
  logic [15:0] io_rdata;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Behavioural model state
  logic [15:0] m_led = '0;
  logic [15:0] m_pipe [2];   // [0] first sync stage, [1] second
  logic [15:0] m_runval = '0;
  int          m_runlen = 0;
  logic [15:0] m_stable = '0;
  logic        m_changed = 1'b0;

  io_switch_led_ctrl #(
    .SW_WIDTH(16), .LED_WIDTH(16), .DEBOUNCE_CYCLES(c_D),
    .LED_ADDR(c_LED), .SW_ADDR(c_SW), .STAT_ADDR(c_STAT)
  ) dut (
    .clk(clk), .rst(rst), .LEDCtrl(LEDCtrl), .SwitchCtrl(SwitchCtrl),
    .addr(addr), .wdata(wdata), .switch_in(switch_in),
    .led_out(led_out), .io_rdata(io_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of one rising edge, using the inputs present before the edge.
  // A new value is accepted once the synchronised input has held the same
  // value on D+1 consecutive edges (reset counts as the start of a run of 0).
  task automatic model_edge();
    logic [15:0] x;
    bit commit;
    if (rst) begin
      m_led     = '0;
      m_pipe[0] = '0;
      m_pipe[1] = '0;
      m_runval  = '0;
      m_runlen  = 1;
      m_stable  = '0;
      m_changed = 1'b0;
    end else begin
      x = m_pipe[1];
      if (x == m_runval) begin
        if (m_runlen < 1000) m_runlen++;
      end else begin
        m_runval = x;
        m_runlen = 1;
      end
      commit = (m_runlen >= c_D + 1) && (m_runval != m_stable);
      if (commit) begin
        m_stable  = m_runval;
        m_changed = 1'b1;
      end else if (SwitchCtrl && addr == c_STAT) begin
        m_changed = 1'b0;
      end
      if (LEDCtrl && addr == c_LED) m_led = wdata[15:0];
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = switch_in;
    end
  endtask

  function automatic logic [15:0] model_rdata();
    if (SwitchCtrl && addr == c_SW)   return m_stable;
    if (SwitchCtrl && addr == c_STAT) return {15'b0, m_changed};
    return 16'h0000;
  endfunction

  // Continuous comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_led", {16'h0, led_out}, {16'h0, m_led});
      chk("model_rdata", {16'h0, io_rdata}, {16'h0, model_rdata()});
    end
  end

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    // 1. Reset
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    chk_en = 1'b1;
    SwitchCtrl = 1'b1; addr = c_SW;
    @(negedge clk);
    chk("reset_led", {16'h0, led_out}, 32'h0);
    chk("reset_sw_rd", {16'h0, io_rdata}, 32'h0);
    step();
    addr = c_STAT;
    @(negedge clk);
    chk("reset_stat_rd", {16'h0, io_rdata}, 32'h0);

    // 2. LED write, then a write to a non-LED address
    step();
    SwitchCtrl = 1'b0;
    LEDCtrl = 1'b1; addr = c_LED; wdata = 32'h1234_A5A5;
    step();
    LEDCtrl = 1'b1; addr = c_OTHER; wdata = 32'h0000_FFFF;
    @(negedge clk);
    chk("led_write", {16'h0, led_out}, 32'hA5A5);
    step();
    LEDCtrl = 1'b0;
    @(negedge clk);
    chk("led_other_addr", {16'h0, led_out}, 32'hA5A5);

    // 4. Short glitch never commits
    switch_in = 16'h0001;
    repeat (3) step();
    switch_in = 16'h0000;
    repeat (10) step();
    SwitchCtrl = 1'b1; addr = c_SW;
    @(negedge clk);
    chk("glitch_sw", {16'h0, io_rdata}, 32'h0);
    step();
    addr = c_STAT;
    @(negedge clk);
    chk("glitch_stat", {16'h0, io_rdata}, 32'h0);

    // 3. Held change commits on edge D+3
    step();
    switch_in = 16'h00F0; addr = c_SW;
    for (int k = 1; k <= 7; k++) begin
      step();
      @(negedge clk);
      chk($sformatf("commit_edge%0d", k), {16'h0, io_rdata},
          (k <= 6) ? 32'h0 : 32'h00F0);
    end

    // 5. Clear on read
    step();
    addr = c_STAT;
    @(negedge clk);
    chk("stat_first_read", {16'h0, io_rdata}, 32'h1);
    step();
    @(negedge clk);
    chk("stat_second_read", {16'h0, io_rdata}, 32'h0);

    // 5b. Commit on the same edge as a status read: set wins
    step();
    switch_in = 16'h0F00; addr = c_SW;
    repeat (6) step();
    addr = c_STAT;
    @(negedge clk);
    chk("stat_pre_commit", {16'h0, io_rdata}, 32'h0);
    step();
    @(negedge clk);
    chk("stat_set_wins", {16'h0, io_rdata}, 32'h1);
    step();
    addr = c_SW;
    @(negedge clk);
    chk("sw_after_commit", {16'h0, io_rdata}, 32'h0F00);

    // 6. Reset mid-debounce
    step();
    switch_in = 16'hFFFF; SwitchCtrl = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0; SwitchCtrl = 1'b1; addr = c_STAT;
    @(negedge clk);
    chk("midrst_led", {16'h0, led_out}, 32'h0);
    chk("midrst_stat", {16'h0, io_rdata}, 32'h0);
    step();
    addr = c_SW;
    for (int k = 2; k <= 7; k++) begin
      step();
      @(negedge clk);
      chk($sformatf("rst_commit_edge%0d", k), {16'h0, io_rdata},
          (k <= 6) ? 32'h0 : 32'hFFFF);
    end
    step();
    addr = c_STAT;
    @(negedge clk);
    chk("rst_commit_stat", {16'h0, io_rdata}, 32'h1);

    // Randomised traffic checked by the model
    for (int i = 0; i < 3000; i++) begin
      int r;
      step();
      r = $urandom_range(0, 99);
      if (r < 4)       switch_in = 16'($urandom);
      else if (r < 10) switch_in = switch_in ^ (16'h1 << $urandom_range(0, 15));
      LEDCtrl    = ($urandom_range(0, 4) == 0);
      SwitchCtrl = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0:       addr = c_LED;
        1:       addr = c_SW;
        2:       addr = c_STAT;
        default: addr = c_OTHER;
      endcase
      wdata = $urandom;
      rst   = ($urandom_range(0, 199) == 0);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
